// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : pipeline memory-access stage with req/ack data memory and MEM/WB
// Revision  : 1.0
// ============================================================================
module mem_stage #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] alu_result,
   input  logic        alu_zero,
   input  logic [31:0] jump_result,
   input  logic [31:0] write_data,
   input  logic [4:0]  write_reg_addr,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic        mem_reg,
   input  logic        branch,
   input  logic        reg_write,
   output logic        stall,
   output logic        pc_src,
   output logic [31:0] branch_target,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic [31:0] read_data_buffered,
   output logic [31:0] alu_result_buffered,
   output logic [4:0]  write_reg_addr_buffered,
   output logic        mem_reg_buffered,
   output logic        reg_write_buffered,
   output logic        misaligned,
   output logic        bus_error
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] c_timeout = 8'(ACK_TIMEOUT);

   state_t      r_state;
   state_t      w_state_next;
   logic [7:0]  r_cnt;
   logic [7:0]  w_cnt_inc;
   logic        w_mem_op;
   logic        w_unaligned;
   logic        w_timeout;

   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_we;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_hold_alu;
   logic [4:0]  r_hold_wra;
   logic        r_hold_mem_reg;
   logic        r_hold_reg_write;

   logic [31:0] r_mwb_rdata;
   logic [31:0] r_mwb_alu;
   logic [4:0]  r_mwb_wra;
   logic        r_mwb_mem_reg;
   logic        r_mwb_reg_write;
   logic        r_misaligned;
   logic        r_bus_error;

   assign w_mem_op    = mem_read | mem_write;
   assign w_unaligned = (alu_result[1:0] != 2'b00);
   assign w_cnt_inc   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
   // Ack has priority: timeout only counts when no ack arrives this cycle.
   assign w_timeout   = (r_state == S_WAIT) && !dmem_ack && (w_cnt_inc >= c_timeout);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      stall        = 1'b0;
      dmem_req     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_mem_op && !w_unaligned) begin
               stall        = 1'b1;
               w_state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            stall    = 1'b1;
            dmem_req = 1'b1;
            if (dmem_ack || w_timeout) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt            <= 8'd0;
         r_addr           <= 32'd0;
         r_wdata          <= 32'd0;
         r_we             <= 1'b0;
         r_rdata          <= 32'd0;
         r_err            <= 1'b0;
         r_hold_alu       <= 32'd0;
         r_hold_wra       <= 5'd0;
         r_hold_mem_reg   <= 1'b0;
         r_hold_reg_write <= 1'b0;
         r_mwb_rdata      <= 32'd0;
         r_mwb_alu        <= 32'd0;
         r_mwb_wra        <= 5'd0;
         r_mwb_mem_reg    <= 1'b0;
         r_mwb_reg_write  <= 1'b0;
         r_misaligned     <= 1'b0;
         r_bus_error      <= 1'b0;
      end else begin
         r_misaligned <= (r_state == S_IDLE) && w_mem_op && w_unaligned;
         r_bus_error  <= (r_state == S_DONE) && r_err;
         case (r_state)
            S_IDLE: begin
               r_cnt <= 8'd0;
               if (w_mem_op && !w_unaligned) begin
                  r_addr           <= alu_result;
                  r_wdata          <= write_data;
                  r_we             <= mem_write;
                  r_rdata          <= 32'd0;
                  r_err            <= 1'b0;
                  r_hold_alu       <= alu_result;
                  r_hold_wra       <= write_reg_addr;
                  r_hold_mem_reg   <= mem_reg;
                  r_hold_reg_write <= reg_write;
                  r_mwb_mem_reg    <= 1'b0;
                  r_mwb_reg_write  <= 1'b0;
               end else begin
                  r_mwb_rdata     <= 32'd0;
                  r_mwb_alu       <= alu_result;
                  r_mwb_wra       <= write_reg_addr;
                  r_mwb_mem_reg   <= mem_reg;
                  r_mwb_reg_write <= reg_write & ~(w_mem_op & w_unaligned);
               end
            end
            S_WAIT: begin
               r_cnt           <= w_cnt_inc;
               r_mwb_mem_reg   <= 1'b0;
               r_mwb_reg_write <= 1'b0;
               if (dmem_ack) begin
                  r_rdata <= r_we ? 32'd0 : dmem_rdata;
               end else if (w_timeout) begin
                  r_rdata <= 32'd0;
                  r_err   <= 1'b1;
               end
            end
            S_DONE: begin
               r_mwb_rdata     <= r_rdata;
               r_mwb_alu       <= r_hold_alu;
               r_mwb_wra       <= r_hold_wra;
               r_mwb_mem_reg   <= r_hold_mem_reg;
               r_mwb_reg_write <= r_hold_reg_write & ~r_err;
            end
            default: begin
               r_cnt <= 8'd0;
            end
         endcase
      end
   end

   assign pc_src                  = branch & alu_zero & ~stall;
   assign branch_target           = jump_result;
   assign dmem_we                 = r_we;
   assign dmem_addr               = r_addr;
   assign dmem_wdata              = r_wdata;
   assign read_data_buffered      = r_mwb_rdata;
   assign alu_result_buffered     = r_mwb_alu;
   assign write_reg_addr_buffered = r_mwb_wra;
   assign mem_reg_buffered        = r_mwb_mem_reg;
   assign reg_write_buffered      = r_mwb_reg_write;
   assign misaligned              = r_misaligned;
   assign bus_error               = r_bus_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : scoreboard bench for mem_stage (ACK_TIMEOUT = 4)
// Revision     : 1.0
// ============================================================================
module tb_mem_stage;

   localparam int c_to = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] alu_result, jump_result, write_data, dmem_rdata;
   logic        alu_zero, mem_read, mem_write, mem_reg, branch, reg_write, dmem_ack;
   logic [4:0]  write_reg_addr;
   logic        stall, pc_src, dmem_req, dmem_we, mem_reg_buffered, reg_write_buffered;
   logic        misaligned, bus_error;
   logic [31:0] branch_target, dmem_addr, dmem_wdata, read_data_buffered, alu_result_buffered;
   logic [4:0]  write_reg_addr_buffered;

   typedef struct {
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  wra;
      logic        mreg;
      logic        rw;
      logic        mis;
      logic        berr;
   } mwb_t;

   mwb_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   mem_stage #(.ACK_TIMEOUT(c_to)) dut (
      .clk(clk), .reset(reset),
      .alu_result(alu_result), .alu_zero(alu_zero), .jump_result(jump_result),
      .write_data(write_data), .write_reg_addr(write_reg_addr),
      .mem_read(mem_read), .mem_write(mem_write), .mem_reg(mem_reg),
      .branch(branch), .reg_write(reg_write),
      .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .read_data_buffered(read_data_buffered), .alu_result_buffered(alu_result_buffered),
      .write_reg_addr_buffered(write_reg_addr_buffered), .mem_reg_buffered(mem_reg_buffered),
      .reg_write_buffered(reg_write_buffered), .misaligned(misaligned), .bus_error(bus_error)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_stall"}, stall, 0);
      check_eq({tag, "_pc_src"}, pc_src, 0);
      check_eq({tag, "_req"}, dmem_req, 0);
      check_eq({tag, "_we"}, dmem_we, 0);
      check_eq({tag, "_addr"}, dmem_addr, 0);
      check_eq({tag, "_wdata"}, dmem_wdata, 0);
      check_eq({tag, "_rd_buf"}, read_data_buffered, 0);
      check_eq({tag, "_alu_buf"}, alu_result_buffered, 0);
      check_eq({tag, "_wra_buf"}, write_reg_addr_buffered, 0);
      check_eq({tag, "_mreg_buf"}, mem_reg_buffered, 0);
      check_eq({tag, "_rw_buf"}, reg_write_buffered, 0);
      check_eq({tag, "_misaligned"}, misaligned, 0);
      check_eq({tag, "_bus_error"}, bus_error, 0);
   endtask

   task automatic set_nop();
      alu_result = 0; alu_zero = 0; jump_result = 0; write_data = 0; write_reg_addr = 0;
      mem_read = 0; mem_write = 0; mem_reg = 0; branch = 0; reg_write = 0;
   endtask

   // Called just after a rising edge; returns just after the edge that loads MEM/WB.
   // ack_k: WAIT cycle (0-based) on which memory acks, negative for never.
   task automatic run_op(input string tag, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wra, input logic mr, input logic mw, input logic mreg,
                         input logic rw, input logic br, input logic zero, input logic [31:0] jt,
                         input int ack_k, input logic [31:0] rdata);
      mwb_t e;
      mwb_t got;
      logic memop, mis, go, tout;
      int   exp_stall, exp_req, exp_pc;
      int   n_stall = 0, n_req = 0, n_pc = 0;
      bit   left = 0;
      memop = mr | mw;
      mis   = memop && (alu[1:0] != 2'b00);
      go    = memop && !mis;
      tout  = go && (ack_k < 0 || ack_k >= c_to);
      e.rd   = (go && !tout && !mw) ? rdata : 32'd0;
      e.alu  = alu;
      e.wra  = wra;
      e.mreg = mreg;
      e.rw   = rw && !mis && !tout;
      e.mis  = mis;
      e.berr = tout;
      exp_stall = !go ? 0 : (tout ? 1 + c_to : 2 + ack_k);
      exp_req   = !go ? 0 : (tout ? c_to : ack_k + 1);
      exp_pc    = (br && zero) ? 1 : 0;

      alu_result = alu; write_data = wd; write_reg_addr = wra; mem_read = mr; mem_write = mw;
      mem_reg = mreg; reg_write = rw; branch = br; alu_zero = zero; jump_result = jt;
      sb.push_back(e);

      for (int c = 0; c < 40 && !left; c++) begin
         @(negedge clk);
         if (stall) n_stall++;
         if (pc_src) begin
            n_pc++;
            check_eq({tag, "_br_target"}, branch_target, jt);
         end
         if (dmem_req) begin
            check_eq({tag, "_dmem_addr"}, dmem_addr, alu);
            check_eq({tag, "_dmem_we"}, dmem_we, mw);
            if (mw) check_eq({tag, "_dmem_wdata"}, dmem_wdata, wd);
            check_eq({tag, "_bubble_rw"}, reg_write_buffered, 0);
            check_eq({tag, "_bubble_mreg"}, mem_reg_buffered, 0);
            if (n_req == ack_k) begin
               dmem_ack = 1; dmem_rdata = rdata;
            end else begin
               dmem_ack = 0; dmem_rdata = 32'hBAD0_BAD0;
            end
            n_req++;
         end else begin
            dmem_ack = 0;
         end
         if (!stall) left = 1;
      end
      if (!left) check_eq({tag, "_stall_stuck"}, 0, 1);
      check_eq({tag, "_stall_cycles"}, n_stall, exp_stall);
      check_eq({tag, "_req_cycles"}, n_req, exp_req);
      check_eq({tag, "_pc_src_cycles"}, n_pc, exp_pc);

      @(posedge clk); #1;
      if (sb.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 0, 1);
      end else begin
         got = sb.pop_front();
         check_eq({tag, "_rd_buf"}, read_data_buffered, got.rd);
         check_eq({tag, "_alu_buf"}, alu_result_buffered, got.alu);
         check_eq({tag, "_wra_buf"}, write_reg_addr_buffered, got.wra);
         check_eq({tag, "_mreg_buf"}, mem_reg_buffered, got.mreg);
         check_eq({tag, "_rw_buf"}, reg_write_buffered, got.rw);
         check_eq({tag, "_misaligned"}, misaligned, got.mis);
         check_eq({tag, "_bus_error"}, bus_error, got.berr);
      end
   endtask

   initial begin
      set_nop();
      dmem_ack = 0; dmem_rdata = 0;
      reset = 1;
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      @(negedge clk) reset = 0;
      @(posedge clk); #1;

      //      tag        alu           wdata         wra  rd wr mr rw br z  jt           ack  rdata
      run_op("nop",      32'd5,        32'd0,        5'd3, 0, 0, 0, 1, 0, 0, 32'd0,        0,  32'd0);
      run_op("load",     32'h100,      32'd0,        5'd7, 1, 0, 1, 1, 0, 0, 32'd0,        2,  32'hDEADBEEF);
      run_op("store",    32'h40,       32'h12345678, 5'd9, 0, 1, 0, 0, 0, 0, 32'd0,        0,  32'hCAFEF00D);
      run_op("mis_load", 32'h102,      32'd0,        5'd4, 1, 0, 1, 1, 0, 0, 32'd0,        0,  32'h11111111);
      run_op("nop2",     32'hABCD,     32'd0,        5'd1, 0, 0, 0, 1, 0, 0, 32'd0,        0,  32'd0);
      run_op("tmo_load", 32'h200,      32'd0,        5'd5, 1, 0, 1, 1, 0, 0, 32'd0,       -1,  32'd0);
      run_op("ack_last", 32'h204,      32'd0,        5'd6, 1, 0, 1, 1, 0, 0, 32'd0,        3,  32'h0BADCAFE);
      run_op("rd_wr",    32'h208,      32'h55AA55AA, 5'd2, 1, 1, 0, 1, 0, 0, 32'd0,        1,  32'h77777777);
      run_op("branch",   32'd0,        32'd0,        5'd0, 0, 0, 0, 0, 1, 1, 32'h200,      0,  32'd0);
      run_op("br_nz",    32'd8,        32'd0,        5'd8, 0, 0, 0, 1, 1, 0, 32'h300,      0,  32'd0);

      // Reset arriving mid-WAIT abandons the access with no write-back.
      alu_result = 32'h300; mem_read = 1; reg_write = 1; write_reg_addr = 5'd12;
      @(negedge clk);
      @(negedge clk);
      check_eq("midwait_req_before", dmem_req, 1);
      reset = 1;
      set_nop();
      #1 check_all_zero("midwait_reset");
      @(negedge clk) reset = 0;
      @(posedge clk); #1;
      run_op("post_rst", 32'h44,       32'd0,        5'd11, 0, 0, 0, 1, 0, 0, 32'd0,       0,  32'd0);
      check_eq("sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined CPU. It sits directly downstream of the EX/MEM register and consumes its buffered outputs. It runs loads and stores against data memory over a req/ack handshake, resolves branches (`branch & alu_zero`), and stalls upstream while a memory access is outstanding. It contains the MEM/WB register feeding write-back.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 16: WAIT cycles without `dmem_ack` before the access is abandoned. Legal range 1..255.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: rising-edge clock.
- `reset` in 1: async active-high reset.
- `alu_result` in 32: address for loads/stores; result for ALU ops.
- `alu_zero` in 1: ALU zero flag.
- `jump_result` in 32: branch target.
- `write_data` in 32: store data (rt value).
- `write_reg_addr` in 5: destination register.
- `mem_read`, `mem_write`, `mem_reg`, `branch`, `reg_write` in 1 each: control bits.
- `stall` out 1: hold the EX/MEM register and all earlier stages.
- `pc_src` out 1: take branch. `branch_target` out 32.
- `dmem_req` out 1, `dmem_we` out 1, `dmem_addr` out 32, `dmem_wdata` out 32: data-memory request.
- `dmem_rdata` in 32, `dmem_ack` in 1: data-memory response.
- `read_data_buffered` out 32, `alu_result_buffered` out 32, `write_reg_addr_buffered` out 5, `mem_reg_buffered` out 1, `reg_write_buffered` out 1: MEM/WB register.
- `misaligned` out 1, `bus_error` out 1: registered one-cycle fault pulses.

## Operation
- States: IDLE, WAIT, DONE.
- A memory op is `mem_read | mem_write`. If both are set, it is treated as a store.
- Alignment: an access is misaligned when `alu_result[1:0] != 0`.
- IDLE, no memory op or misaligned:
  - `stall=0`.
  - MEM/WB loads the inputs.
  - `read_data_buffered` loads 0.
- IDLE, misaligned memory op:
  - No request is issued.
  - `reg_write_buffered` loads 0.
  - `misaligned` pulses 1 the next cycle.
- IDLE, aligned memory op:
  - `stall=1` (combinational).
  - Latch addr, data and we.
  - Counter clears to 0.
  - Go to WAIT.
- WAIT:
  - `dmem_req=1`. `dmem_addr`, `dmem_wdata` and `dmem_we` are driven from the latches and stay stable.
  - `stall=1`. Counter increments each cycle.
  - On `dmem_ack=1`: capture `dmem_rdata` (loads only; stores capture 0), then go to DONE.
  - Else, if the counter reaches `ACK_TIMEOUT`: capture 0, set the error flag, go to DONE.
- DONE:
  - `dmem_req=0`, `stall=0`.
  - MEM/WB loads the held inputs with the captured read data.
  - If a timeout occurred: `reg_write_buffered=0` and `bus_error` pulses next cycle.
  - Go to IDLE.
- Every cycle with `stall=1`, MEM/WB loads a bubble: `reg_write_buffered=0`, `mem_reg_buffered=0`. Other MEM/WB fields hold their values.
- Branch outputs:
  - `pc_src = branch & alu_zero & ~stall`, combinational.
  - `branch_target = jump_result`, combinational.
  - The branch is therefore asserted exactly once, in the cycle the instruction leaves the stage.
- `dmem_ack` outside WAIT is ignored.
- Ack on the same cycle the counter reaches `ACK_TIMEOUT`: ack wins, no `bus_error`.

## Timing
- Reset (async): state IDLE, counter 0. All registered outputs are 0: MEM/WB fields, `misaligned`, `bus_error`, and the latches behind `dmem_*`.
  - `dmem_req` deasserts immediately, including mid-WAIT. The abandoned access produces no write-back.
- Non-memory instruction: 1-cycle latency to MEM/WB, no stall.
- Memory op with ack k cycles after entering WAIT (k≥0):
  - Stall lasts 2+k cycles (IDLE cycle, 1+k WAIT cycles).
  - Then DONE.
  - MEM/WB is valid at the edge ending DONE.
  - Total latency is 3+k cycles.
- Timeout: `dmem_req` is held for `ACK_TIMEOUT` cycles. `bus_error` is high the cycle after DONE.
- Back-to-back memory ops: the second enters IDLE the cycle after DONE. There is at most one outstanding request.
- The counter saturates and never wraps.

## Test plan
- After reset, apply `alu_result=5`, `reg_write=1`, `write_reg_addr=3`, no memory op. Next cycle: `alu_result_buffered=5`, `reg_write_buffered=1`, `write_reg_addr_buffered=3`, `stall` is never 1.
- Load with `alu_result=0x100`, memory acks 2 cycles into WAIT with `dmem_rdata=0xDEADBEEF`:
  - `stall` is high 4 cycles.
  - `dmem_addr=0x100` is stable and `dmem_we=0`.
  - `read_data_buffered=0xDEADBEEF`, `reg_write_buffered` is 0 during the stall and 1 after.
- Store with `alu_result=0x40`, `write_data=0x12345678`, immediate ack: `dmem_we=1`, `dmem_wdata=0x12345678`, stall is 2 cycles, and the MEM/WB bubble carries `reg_write_buffered=0`.
- Load with `alu_result=0x102`: `dmem_req` is never asserted, `misaligned=1` for 1 cycle, `reg_write_buffered=0`, no stall.
- `ACK_TIMEOUT=4`, load never acked:
  - `dmem_req` is high 4 cycles.
  - `bus_error` pulses.
  - `read_data_buffered=0`, `reg_write_buffered=0`.
  - A separate run acking exactly on the 4th WAIT cycle shows no `bus_error`.
- `branch=1`, `alu_zero=1`, `jump_result=0x200`: `pc_src=1` with target 0x200 for exactly one cycle. Assert `reset` mid-WAIT of a load: `dmem_req` drops immediately and all outputs are 0.
